// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Purpose  : Memory-access / write-back pipeline stage. Accepts one
//            instruction per cycle from execute, runs a req/ack handshake
//            with the MMU for loads and stores, and drives the register-file
//            write port back to decode. Upstream is stalled while an access
//            is outstanding; unanswered accesses are aborted after
//            ACK_TIMEOUT cycles.
// Ports    : clk, reset (async, active-low)
//            upstream : valid_in, alu_result, store_data, addr_d_in, wb_en_in,
//                       read_mmu, write_mmu, byte_select_mmu, stall
//            MMU      : mem_req, mem_we, mem_byte, mem_addr, mem_wdata,
//                       mem_rdata, mem_ack
//            regfile  : wb_write, wb_addr_d, wb_data
//            status   : mem_error (one-cycle pulse)
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  addr_d_in,
    input  logic        wb_en_in,
    input  logic        read_mmu,
    input  logic        write_mmu,
    input  logic        byte_select_mmu,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_byte,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_write,
    output logic [4:0]  wb_addr_d,
    output logic [31:0] wb_data,
    output logic        mem_error
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    // Counter value at which an unanswered access is abandoned.
    localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic        mem_byte_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        ld_wb_q;      // outstanding load must write back on ack
    logic [4:0]  ld_addr_q;
    logic        wb_write_q;
    logic [4:0]  wb_addr_q;
    logic [31:0] wb_data_q;
    logic        mem_error_q;

    logic        w_stall;
    logic        w_accept;
    logic        w_is_mem;
    logic        w_bad;
    logic        w_wb_req;
    logic        w_ld_done_wb;
    logic        w_accept_nonmem_wb;
    logic [7:0]  w_lane;
    logic [31:0] w_ld_data;

    assign w_stall  = (state_q == WAIT_ACK) && !mem_ack;
    assign w_accept = valid_in && !w_stall;
    assign w_is_mem = read_mmu || write_mmu;
    // Simultaneous load+store is illegal; word accesses must be aligned.
    assign w_bad    = (read_mmu && write_mmu) ||
                      (w_is_mem && !byte_select_mmu && (alu_result[1:0] != 2'b00));
    assign w_wb_req = wb_en_in && (addr_d_in != 5'd0);

    assign w_ld_done_wb       = (state_q == WAIT_ACK) && mem_ack && !mem_we_q && ld_wb_q;
    assign w_accept_nonmem_wb = w_accept && !w_is_mem && !w_bad && w_wb_req;

    always_comb begin
        w_lane = mem_rdata[7:0];
        case (mem_addr_q[1:0])
            2'd0: w_lane = mem_rdata[7:0];
            2'd1: w_lane = mem_rdata[15:8];
            2'd2: w_lane = mem_rdata[23:16];
            2'd3: w_lane = mem_rdata[31:24];
            default: w_lane = mem_rdata[7:0];
        endcase
    end

    assign w_ld_data = mem_byte_q ? {{24{w_lane[7]}}, w_lane} : mem_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_byte_q  <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            ld_wb_q     <= 1'b0;
            ld_addr_q   <= 5'd0;
            wb_write_q  <= 1'b0;
            wb_addr_q   <= 5'd0;
            wb_data_q   <= 32'd0;
            mem_error_q <= 1'b0;
        end else begin
            wb_write_q  <= 1'b0;
            mem_error_q <= 1'b0;

            if (state_q == WAIT_ACK) begin
                if (mem_ack) begin
                    mem_req_q <= 1'b0;
                    state_q   <= IDLE;
                    if (w_ld_done_wb) begin
                        wb_write_q <= 1'b1;
                        wb_addr_q  <= ld_addr_q;
                        wb_data_q  <= w_ld_data;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    mem_req_q   <= 1'b0;
                    mem_error_q <= 1'b1;
                    state_q     <= IDLE;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end

            // Acceptance is evaluated after the ack handling so that an
            // instruction taken on the ack edge overrides the return to IDLE.
            if (w_accept) begin
                if (w_bad) begin
                    mem_error_q <= 1'b1;
                end else if (w_is_mem) begin
                    state_q     <= WAIT_ACK;
                    cnt_q       <= 8'd0;
                    mem_req_q   <= 1'b1;
                    mem_we_q    <= write_mmu;
                    mem_byte_q  <= byte_select_mmu;
                    mem_addr_q  <= alu_result;
                    mem_wdata_q <= byte_select_mmu ? {4{store_data[7:0]}} : store_data;
                    ld_wb_q     <= w_wb_req;
                    ld_addr_q   <= addr_d_in;
                end else if (w_wb_req && !w_ld_done_wb) begin
                    // A completing load owns the write port this cycle.
                    wb_write_q <= 1'b1;
                    wb_addr_q  <= addr_d_in;
                    wb_data_q  <= alu_result;
                end
            end
        end
    end

    // Upstream must never present a writing non-memory instruction on the
    // edge where a load write-back completes.
    a_no_wb_conflict: assert property (@(posedge clk) disable iff (!reset)
        !(w_ld_done_wb && w_accept_nonmem_wb));

    assign stall     = w_stall;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_byte  = mem_byte_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_write  = wb_write_q;
    assign wb_addr_d = wb_addr_q;
    assign wb_data   = wb_data_q;
    assign mem_error = mem_error_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_stage
// Purpose  : Self-checking bench for mem_wb_stage. Expected register-file
//            writes are queued when an instruction is driven and popped by a
//            monitor whenever wb_write is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  addr_d_in;
    logic        wb_en_in;
    logic        read_mmu;
    logic        write_mmu;
    logic        byte_select_mmu;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic        mem_byte;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        wb_write;
    logic [4:0]  wb_addr_d;
    logic [31:0] wb_data;
    logic        mem_error;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [36:0] sb_q[$];   // {addr[4:0], data[31:0]}

    mem_wb_stage #(.ACK_TIMEOUT(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .valid_in        (valid_in),
        .alu_result      (alu_result),
        .store_data      (store_data),
        .addr_d_in       (addr_d_in),
        .wb_en_in        (wb_en_in),
        .read_mmu        (read_mmu),
        .write_mmu       (write_mmu),
        .byte_select_mmu (byte_select_mmu),
        .stall           (stall),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_byte        (mem_byte),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_ack         (mem_ack),
        .wb_write        (wb_write),
        .wb_addr_d       (wb_addr_d),
        .wb_data         (wb_data),
        .mem_error       (mem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Write-back monitor: every strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (reset && wb_write) begin
            if (sb_q.size() == 0) begin
                chk("wb_unexpected", {31'd0, wb_write}, 32'd0);
            end else begin
                logic [36:0] e;
                e = sb_q.pop_front();
                chk("wb_addr", {27'd0, wb_addr_d}, {27'd0, e[36:32]});
                chk("wb_data", wb_data, e[31:0]);
            end
        end
    end

    task automatic issue(input logic rd, input logic wr, input logic bsel,
                         input logic [31:0] alu, input logic [31:0] sd,
                         input logic [4:0] rdst, input logic wen);
        valid_in        = 1'b1;
        read_mmu        = rd;
        write_mmu       = wr;
        byte_select_mmu = bsel;
        alu_result      = alu;
        store_data      = sd;
        addr_d_in       = rdst;
        wb_en_in        = wen;
        @(posedge clk);
        #1;
        valid_in  = 1'b0;
        read_mmu  = 1'b0;
        write_mmu = 1'b0;
    endtask

    // Hold off the ack for 'waits' cycles checking the request is stable,
    // then return one ack pulse carrying 'rdata'.
    task automatic serve(input int unsigned waits, input logic [31:0] rdata,
                         input logic [31:0] ea, input logic ewe, input logic eb,
                         input logic [31:0] ewd);
        for (int i = 0; i < int'(waits); i++) begin
            @(negedge clk);
            chk("wait_stall", {31'd0, stall}, 32'd1);
            chk("wait_req", {31'd0, mem_req}, 32'd1);
            chk("wait_addr", mem_addr, ea);
            chk("wait_we", {31'd0, mem_we}, {31'd0, ewe});
            chk("wait_byte", {31'd0, mem_byte}, {31'd0, eb});
            if (ewe) chk("wait_wdata", mem_wdata, ewd);
            @(posedge clk);
            #1;
        end
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        @(negedge clk);
        chk("ack_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("post_ack_req", {31'd0, mem_req}, 32'd0);
    endtask

    task automatic check_error_op(input string tag, input logic rd, input logic wr,
                                  input logic [31:0] alu);
        issue(rd, wr, 1'b0, alu, 32'h0, 5'd6, 1'b1);
        @(negedge clk);
        chk({tag, "_err"}, {31'd0, mem_error}, 32'd1);
        chk({tag, "_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
        @(negedge clk);
        chk({tag, "_err_clr"}, {31'd0, mem_error}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; valid_in = 1'b0; alu_result = '0; store_data = '0;
        addr_d_in = '0; wb_en_in = 1'b0; read_mmu = 1'b0; write_mmu = 1'b0;
        byte_select_mmu = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_wb", {31'd0, wb_write}, 32'd0);
        chk("rst_wbdata", wb_data, 32'd0);
        chk("rst_err", {31'd0, mem_error}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Non-memory op; data must hold once the strobe drops.
        sb_q.push_back({5'd3, 32'h12345678});
        issue(1'b0, 1'b0, 1'b0, 32'h12345678, 32'h0, 5'd3, 1'b1);
        @(negedge clk);
        chk("alu_stall", {31'd0, stall}, 32'd0);
        chk("alu_wb", {31'd0, wb_write}, 32'd1);
        @(negedge clk);
        chk("alu_wb_one", {31'd0, wb_write}, 32'd0);
        chk("alu_hold", wb_data, 32'h12345678);

        // Non-memory op to r0 is suppressed (monitor flags any strobe).
        issue(1'b0, 1'b0, 1'b0, 32'hCAFEF00D, 32'h0, 5'd0, 1'b1);
        @(negedge clk);
        chk("r0_alu_wb", {31'd0, wb_write}, 32'd0);

        // Word load at 0x100, three wait cycles.
        sb_q.push_back({5'd5, 32'hDEADBEEF});
        issue(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 5'd5, 1'b1);
        serve(3, 32'hDEADBEEF, 32'h100, 1'b0, 1'b0, 32'h0);

        // Byte load at 0x103: lane 3 = 0x80, sign-extended.
        sb_q.push_back({5'd8, 32'hFFFFFF80});
        issue(1'b1, 1'b0, 1'b1, 32'h103, 32'h0, 5'd8, 1'b1);
        serve(1, 32'h80FF0000, 32'h103, 1'b0, 1'b1, 32'h0);

        // Byte load at 0x101: lane 1 = 0x7F, positive.
        sb_q.push_back({5'd9, 32'h0000007F});
        issue(1'b1, 1'b0, 1'b1, 32'h101, 32'h0, 5'd9, 1'b1);
        serve(0, 32'h00007F00, 32'h101, 1'b0, 1'b1, 32'h0);

        // Byte store: replicated data, no write-back.
        issue(1'b0, 1'b1, 1'b1, 32'h300, 32'h000000A5, 5'd4, 1'b0);
        serve(2, 32'h0, 32'h300, 1'b1, 1'b1, 32'hA5A5A5A5);

        // Word store.
        issue(1'b0, 1'b1, 1'b0, 32'h304, 32'h11223344, 5'd4, 1'b0);
        serve(1, 32'h0, 32'h304, 1'b1, 1'b0, 32'h11223344);

        // Illegal accesses.
        check_error_op("misalign", 1'b1, 1'b0, 32'h102);
        check_error_op("rdwr", 1'b1, 1'b1, 32'h200);

        // Load into r0: access performed, no write-back.
        issue(1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 5'd0, 1'b1);
        serve(1, 32'h55555555, 32'h200, 1'b0, 1'b0, 32'h0);

        // Ack on the last allowed cycle (counter = ACK_TIMEOUT-1) still wins.
        sb_q.push_back({5'd10, 32'h0BADC0DE});
        issue(1'b1, 1'b0, 1'b0, 32'h208, 32'h0, 5'd10, 1'b1);
        serve(3, 32'h0BADC0DE, 32'h208, 1'b0, 1'b0, 32'h0);

        // Timeout: request held four cycles, then error; late ack ignored.
        issue(1'b1, 1'b0, 1'b0, 32'h400, 32'h0, 5'd7, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("to_req", {31'd0, mem_req}, 32'd1);
            chk("to_err_low", {31'd0, mem_error}, 32'd0);
        end
        @(negedge clk);
        chk("to_err", {31'd0, mem_error}, 32'd1);
        chk("to_req_drop", {31'd0, mem_req}, 32'd0);
        chk("to_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        mem_ack = 1'b1; mem_rdata = 32'h99999999;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_err", {31'd0, mem_error}, 32'd0);
        chk("late_ack_req", {31'd0, mem_req}, 32'd0);

        // Reset in the middle of an access.
        issue(1'b1, 1'b0, 1'b0, 32'h500, 32'h0, 5'd9, 1'b1);
        @(negedge clk);
        chk("mid_req", {31'd0, mem_req}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        chk("mid_rst_wb", {31'd0, wb_write}, 32'd0);
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        reset = 1'b1;
        sb_q.push_back({5'd11, 32'hA5A50F0F});
        issue(1'b1, 1'b0, 1'b0, 32'h600, 32'h0, 5'd11, 1'b1);
        serve(2, 32'hA5A50F0F, 32'h600, 1'b0, 1'b0, 32'h0);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
